// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame scheduler.
// Build option: UART_FRAME_CHECKSUM_EN appends an XOR checksum byte.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARB       = 3'd1,
    S_LOAD      = 3'd2,
    S_STROBE    = 3'd3,
    S_WAIT_LOW  = 3'd4,
    S_WAIT_HIGH = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam logic [7:0] SYNC_DEF = 8'hA5;
  localparam logic [7:0] ID0_DEF  = 8'h01;
  localparam logic [7:0] ID1_DEF  = 8'h02;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = 5;
`else
  localparam int FRAME_LEN = 4;
`endif

  localparam int IDX_W = 3;

endpackage

// File: rtl/uart_rr_arb.sv
// Two-way round-robin arbiter; last_grant resets to 1 so req0 wins
// the first tie.
module uart_rr_arb
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_take,
  output logic o_valid,
  output logic o_gnt
);

  logic r_last;
  logic w_gnt;

  always_comb begin
    w_gnt = i_req1;
    if (i_req0 && i_req1) begin
      w_gnt = ~r_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (i_take && o_valid) begin
      r_last <= w_gnt;
    end
  end

  assign o_valid = i_req0 | i_req1;
  assign o_gnt   = w_gnt;

endmodule

// File: rtl/uart_frame_sched.sv
// Frames two requesters' payloads onto a byte-wide UART transmitter.
// Build option: UART_FRAME_CHECKSUM_EN adds CHK = ID ^ hi ^ lo.
module uart_frame_sched
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_DEF,
  parameter logic [7:0] ID0       = ID0_DEF,
  parameter logic [7:0] ID1       = ID1_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [15:0] data1,
  output logic        ack1,
  input  logic        tx_ready,
  output logic        start_tx,
  output logic [7:0]  TX_data,
  output logic        busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [15:0]      r_data;
  logic [7:0]       r_id;
  logic             r_who;
  logic [7:0]       r_tx;

  logic             w_valid;
  logic             w_gnt;
  logic [7:0]       w_byte;

  uart_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_req0  (req0),
    .i_req1  (req1),
    .i_take  (r_state == S_ARB),
    .o_valid (w_valid),
    .o_gnt   (w_gnt)
  );

  always_comb begin
    w_byte = SYNC_BYTE;
    case (r_idx)
      3'd1:    w_byte = r_id;
      3'd2:    w_byte = r_data[15:8];
      3'd3:    w_byte = r_data[7:0];
`ifdef UART_FRAME_CHECKSUM_EN
      3'd4:    w_byte = r_id ^ r_data[15:8] ^ r_data[7:0];
`endif
      default: w_byte = SYNC_BYTE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_data  <= '0;
      r_id    <= '0;
      r_who   <= 1'b0;
      r_tx    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) r_state <= S_ARB;
        end
        S_ARB: begin
          if (w_valid) begin
            r_who   <= w_gnt;
            r_data  <= w_gnt ? data1 : data0;
            r_id    <= w_gnt ? ID1 : ID0;
            r_idx   <= '0;
            r_state <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          r_tx <= w_byte;
          if (tx_ready) r_state <= S_STROBE;
        end
        // Ready lost before the strobe: go back and wait again
        S_STROBE: begin
          r_state <= tx_ready ? S_WAIT_LOW : S_LOAD;
        end
        S_WAIT_LOW: begin
          if (!tx_ready) r_state <= S_WAIT_HIGH;
        end
        S_WAIT_HIGH: begin
          if (tx_ready) begin
            if (r_idx == LAST_IDX) begin
              r_state <= S_DONE;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign start_tx = (r_state == S_STROBE) && tx_ready;
  assign ack0     = (r_state == S_DONE) && !r_who;
  assign ack1     = (r_state == S_DONE) && r_who;
  assign busy     = (r_state != S_IDLE);
  assign TX_data  = r_tx;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed bench for uart_frame_sched; honours UART_FRAME_CHECKSUM_EN.
module tb_uart_frame_sched;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0;
  logic        req1 = 1'b0;
  logic [15:0] data0 = '0;
  logic [15:0] data1 = '0;
  logic        ack0, ack1;
  logic        tx_ready;
  logic        start_tx;
  logic [7:0]  TX_data;
  logic        busy;
  logic        force_low = 1'b0;
  int          tx_cnt = 0;

  int checks = 0;
  int failures = 0;
  logic [7:0] q_bytes[$];
  int         ack_q[$];

  uart_frame_sched dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .data0    (data0),
    .ack0     (ack0),
    .req1     (req1),
    .data1    (data1),
    .ack1     (ack1),
    .tx_ready (tx_ready),
    .start_tx (start_tx),
    .TX_data  (TX_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // UART model: busy for 10 cycles after each start strobe
  always @(posedge clk) begin
    if (start_tx) tx_cnt <= 10;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end
  assign tx_ready = (tx_cnt == 0) && !force_low;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (start_tx) begin
        q_bytes.push_back(TX_data);
        chk("start_while_busy", {31'd0, tx_ready}, 32'd1);
      end
      if (ack0) ack_q.push_back(0);
      if (ack1) ack_q.push_back(1);
    end
  end

  task automatic wait_ack(input int n);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (ack0 || ack1) got++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    chk("ack_count", got, n);
    @(negedge clk);
  endtask

  task automatic check_frame(input string name, input logic [7:0] id,
                             input logic [15:0] d, input logic [7:0] ck);
    logic [7:0] e[5];
    e[0] = 8'hA5;
    e[1] = id;
    e[2] = d[15:8];
    e[3] = d[7:0];
    e[4] = ck;
    chk({name, "_len"}, q_bytes.size(), NB);
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("%s_b%0d", name, i),
          (i < q_bytes.size()) ? {24'd0, q_bytes[i]} : 32'hDEAD,
          {24'd0, e[i]});
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] first_ack();
    return (ack_q.size() > 0) ? ack_q[0] : 32'hF;
  endfunction

  typedef struct {
    logic        r0;
    logic        r1;
    logic [15:0] d0;
    logic [15:0] d1;
    int          who;
    logic [7:0]  id;
    logic [15:0] pay;
    logic [7:0]  ck;
  } vec_t;

  vec_t vt[5];

  initial begin
    int n;
    vt[0] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 0, 8'h01, 16'h1234, 8'h27};
    vt[1] = '{1'b0, 1'b1, 16'h0000, 16'hABCD, 1, 8'h02, 16'hABCD, 8'h64};
    vt[2] = '{1'b1, 1'b1, 16'hFF00, 16'h5A5A, 0, 8'h01, 16'hFF00, 8'hFE};
    vt[3] = '{1'b1, 1'b1, 16'hFF00, 16'h5A5A, 1, 8'h02, 16'h5A5A, 8'h02};
    vt[4] = '{1'b1, 1'b1, 16'h0001, 16'h5A5A, 0, 8'h01, 16'h0001, 8'h00};

    repeat (3) @(negedge clk);
    chk("reset_outs", {20'd0, start_tx, TX_data, ack0, ack1, busy}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      q_bytes.delete();
      ack_q.delete();
      req0  = vt[i].r0;
      req1  = vt[i].r1;
      data0 = vt[i].d0;
      data1 = vt[i].d1;
      wait_ack(1);
      chk($sformatf("vec%0d_ack", i), first_ack(), vt[i].who);
      chk($sformatf("vec%0d_nack", i), ack_q.size(), 1);
      check_frame($sformatf("vec%0d", i), vt[i].id, vt[i].pay, vt[i].ck);
    end

    // Tie held from reset: grants alternate 0,1,0,1
    pulse_reset();
    q_bytes.delete();
    ack_q.delete();
    data0 = 16'h1111;
    data1 = 16'h2222;
    req0  = 1'b1;
    req1  = 1'b1;
    wait_ack(4);
    chk("tie_nack", ack_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tie_order%0d", i),
          (i < ack_q.size()) ? ack_q[i] : 32'hF, i % 2);
    end
    chk("tie_nbytes", q_bytes.size(), 4 * NB);

    // Payload latched at grant
    q_bytes.delete();
    ack_q.delete();
    data1 = 16'hBEEF;
    req1  = 1'b1;
    n = 0;
    while (!start_tx && n < 500) begin
      @(negedge clk);
      n++;
    end
    data1 = 16'h0000;
    req1  = 1'b0;
    wait_ack(1);
    chk("latch_ack", first_ack(), 1);
    check_frame("latch", 8'h02, 16'hBEEF, 8'h53);

    // Backpressure in LOAD
    q_bytes.delete();
    ack_q.delete();
    force_low = 1'b1;
    data0 = 16'hC3A5;
    req0  = 1'b1;
    n = 0;
    repeat (50) begin
      @(negedge clk);
      if (start_tx) n++;
    end
    chk("bp_no_start", n, 0);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    force_low = 1'b0;
    wait_ack(1);
    check_frame("bp", 8'h01, 16'hC3A5, 8'h67);

    // Reset during byte 2
    q_bytes.delete();
    ack_q.delete();
    data0 = 16'h1234;
    req0  = 1'b1;
    n = 0;
    for (int c = 0; c < 2000 && n < 3; c++) begin
      @(negedge clk);
      if (start_tx) n++;
    end
    chk("mid_reached", n, 3);
    reset = 1'b1;
    #1;
    chk("mid_outs", {20'd0, start_tx, TX_data, ack0, ack1, busy}, 32'd0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_no_ack", ack_q.size(), 0);
    q_bytes.delete();
    data0 = 16'h1234;
    data1 = 16'h9999;
    req0  = 1'b1;
    req1  = 1'b1;
    wait_ack(1);
    chk("mid_tie_ack", first_ack(), 0);
    check_frame("mid_restart", 8'h01, 16'h1234, 8'h27);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
